// File: rtl/pdes_run_ctl.sv
// pdes_run_ctl -- dispatch decode, AEG register file and run control for the
// PDES personality.
//
// Decodes start/abort instructions, pulses a start to every enabled engine,
// collects per-engine completions and reduces them into a minimum GVT, a
// summed event count and a run-cycle count, exposed through read-only AEGs.
//
// Optional feature: define PDES_WATCHDOG_EN to enable the run watchdog
// (AEG4 = cycle limit, 0 disables). Without it AEG4 is plain storage.
//
// Ports:
//   clk, i_reset            clock, asynchronous active-high reset
//   disp_inst_vld/inst      instruction strobe and code (0 start, 1 abort)
//   disp_aeg_*              AEG index, read/write strobes, write data
//   disp_aeg_cnt            constant NA
//   disp_exception          one-cycle exception flags
//                           [0] bad inst, [1] bad index, [2] timeout, [3] busy write
//   disp_idle/disp_stall    dispatch handshake
//   disp_rtn_data_vld/data  read return, one cycle after disp_aeg_rd
//   aeg_cfg                 AEG[0..4] flattened, AEG0 in the LSBs
//   eng_start/eng_abort     one-cycle pulses to the engines
//   eng_done/gvt/events     per-engine completion with its GVT and event count
module pdes_run_ctl #(
    parameter int NA      = 16,
    parameter int NUM_ENG = 4,
    parameter int GVT_W   = 16,
    parameter int STAT_W  = 48
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      disp_inst_vld,
    input  logic [4:0]                disp_inst,
    input  logic [17:0]               disp_aeg_idx,
    input  logic                      disp_aeg_rd,
    input  logic                      disp_aeg_wr,
    input  logic [63:0]               disp_aeg_wr_data,
    output logic [17:0]               disp_aeg_cnt,
    output logic [15:0]               disp_exception,
    output logic                      disp_idle,
    output logic                      disp_stall,
    output logic                      disp_rtn_data_vld,
    output logic [63:0]               disp_rtn_data,
    output logic [5*64-1:0]           aeg_cfg,
    output logic [NUM_ENG-1:0]        eng_start,
    output logic                      eng_abort,
    input  logic [NUM_ENG-1:0]        eng_done,
    input  logic [NUM_ENG*GVT_W-1:0]  eng_gvt,
    input  logic [NUM_ENG*STAT_W-1:0] eng_events
);
    localparam int IW = $clog2(NA);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [63:0]         aeg [NA];
    logic [NUM_ENG-1:0]  mask;
    logic [NUM_ENG-1:0]  pending;
    logic [GVT_W-1:0]    gvt_acc;
    logic [63:0]         ev_acc;
    logic [63:0]         cyc_acc;
    logic                aborted;
    logic                timeout;

    // ---------------- dispatch decode ----------------
    logic          idx_ok, is_cfg, is_ro;
    logic [IW-1:0] idx;
    logic          start_req, abort_req, bad_inst, bad_idx, wr_busy, wr_en;
    logic [63:0]   status, rd_val;

    assign idx       = disp_aeg_idx[IW-1:0];
    assign idx_ok    = disp_aeg_idx < 18'(NA);
    assign is_cfg    = idx_ok && (idx <= IW'(4));
    assign is_ro     = idx_ok && (idx >= IW'(5)) && (idx <= IW'(8));
    assign start_req = disp_inst_vld && (disp_inst == 5'd0);
    assign abort_req = disp_inst_vld && (disp_inst == 5'd1);
    assign bad_inst  = disp_inst_vld && (disp_inst > 5'd1);
    assign bad_idx   = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
    // Config registers are frozen while a run is in flight.
    assign wr_busy   = disp_aeg_wr && is_cfg && (state != S_IDLE);
    assign wr_en     = disp_aeg_wr && idx_ok && !is_ro && !wr_busy;

    assign status = {60'b0, aborted, timeout, state};
    assign rd_val = !idx_ok            ? 64'b0 :
                    (idx == IW'(5))    ? status : aeg[idx];

    assign disp_aeg_cnt = 18'(NA);
    assign disp_idle    = (state == S_IDLE);
    assign disp_stall   = (state != S_IDLE) || start_req;
    assign aeg_cfg      = {aeg[4], aeg[3], aeg[2], aeg[1], aeg[0]};

    // ---------------- completion reduction ----------------
    // All engines finishing in the same cycle fold into one update.
    logic [NUM_ENG-1:0] pend_nxt;
    logic [GVT_W-1:0]   gvt_nxt;
    logic [63:0]        ev_nxt;
    logic [63:0]        cyc_nxt;

    always_comb begin
        pend_nxt = pending;
        gvt_nxt  = gvt_acc;
        ev_nxt   = ev_acc;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_done[i] && pending[i]) begin
                pend_nxt[i] = 1'b0;
                if (eng_gvt[i*GVT_W +: GVT_W] < gvt_nxt)
                    gvt_nxt = eng_gvt[i*GVT_W +: GVT_W];
                ev_nxt = ev_nxt + 64'(eng_events[i*STAT_W +: STAT_W]);
            end
        end
    end

    // Count including the current RUN cycle, saturating.
    assign cyc_nxt = (cyc_acc == '1) ? cyc_acc : cyc_acc + 64'd1;

    logic wd_fire;
`ifdef PDES_WATCHDOG_EN
    assign wd_fire = (state == S_RUN) && !abort_req &&
                     (aeg[4] != 64'b0) && (cyc_nxt == aeg[4]);
`else
    assign wd_fire = 1'b0;
`endif

    // ---------------- control FSM + register file ----------------
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= S_IDLE;
            mask              <= '0;
            pending           <= '0;
            gvt_acc           <= '0;
            ev_acc            <= '0;
            cyc_acc           <= '0;
            aborted           <= 1'b0;
            timeout           <= 1'b0;
            eng_start         <= '0;
            eng_abort         <= 1'b0;
            disp_exception    <= '0;
            disp_rtn_data_vld <= 1'b0;
            disp_rtn_data     <= '0;
            for (int i = 0; i < NA; i++) aeg[i] <= '0;
        end else begin
            eng_start         <= '0;
            eng_abort         <= 1'b0;
            disp_exception    <= {12'b0, wr_busy, wd_fire, bad_idx, bad_inst};
            disp_rtn_data_vld <= disp_aeg_rd;
            disp_rtn_data     <= disp_aeg_rd ? rd_val : 64'b0;
            if (wr_en) aeg[idx] <= disp_aeg_wr_data;

            case (state)
                S_IDLE: if (start_req) begin
                    mask      <= aeg[3][NUM_ENG-1:0];
                    pending   <= aeg[3][NUM_ENG-1:0];
                    eng_start <= aeg[3][NUM_ENG-1:0];
                    state     <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    gvt_acc <= '1;
                    ev_acc  <= '0;
                    cyc_acc <= '0;
                    aborted <= 1'b0;
                    timeout <= 1'b0;
                    state   <= (mask == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    cyc_acc <= cyc_nxt;
                    gvt_acc <= gvt_nxt;
                    ev_acc  <= ev_nxt;
                    pending <= pend_nxt;
                    // Abort beats a simultaneous final completion.
                    if (abort_req) begin
                        eng_abort <= 1'b1;
                        aborted   <= 1'b1;
                        aeg[8]    <= cyc_nxt;
                        state     <= S_IDLE;
                    end else if (wd_fire) begin
                        eng_abort <= 1'b1;
                        timeout   <= 1'b1;
                        aeg[8]    <= cyc_nxt;
                        state     <= S_IDLE;
                    end else if (pend_nxt == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    aeg[6] <= 64'(gvt_acc);
                    aeg[7] <= ev_acc;
                    aeg[8] <= cyc_acc;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdes_run_ctl.sv
module tb_pdes_run_ctl;
    localparam int NA = 16, NE = 4, GW = 16, SW = 48;

    logic           clk = 1'b0;
    logic           i_reset;
    logic           disp_inst_vld;
    logic [4:0]     disp_inst;
    logic [17:0]    disp_aeg_idx;
    logic           disp_aeg_rd, disp_aeg_wr;
    logic [63:0]    disp_aeg_wr_data;
    logic [17:0]    disp_aeg_cnt;
    logic [15:0]    disp_exception;
    logic           disp_idle, disp_stall, disp_rtn_data_vld;
    logic [63:0]    disp_rtn_data;
    logic [319:0]   aeg_cfg;
    logic [NE-1:0]  eng_start;
    logic           eng_abort;
    logic [NE-1:0]  eng_done;
    logic [NE*GW-1:0] eng_gvt;
    logic [NE*SW-1:0] eng_events;

    pdes_run_ctl #(.NA(NA), .NUM_ENG(NE), .GVT_W(GW), .STAT_W(SW)) dut (
        .clk(clk), .i_reset(i_reset),
        .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
        .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd),
        .disp_aeg_wr(disp_aeg_wr), .disp_aeg_wr_data(disp_aeg_wr_data),
        .disp_aeg_cnt(disp_aeg_cnt), .disp_exception(disp_exception),
        .disp_idle(disp_idle), .disp_stall(disp_stall),
        .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
        .aeg_cfg(aeg_cfg), .eng_start(eng_start), .eng_abort(eng_abort),
        .eng_done(eng_done), .eng_gvt(eng_gvt), .eng_events(eng_events)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) tick();
    endtask

    task automatic wr(input logic [17:0] idx, input logic [63:0] d);
        disp_aeg_wr = 1'b1; disp_aeg_idx = idx; disp_aeg_wr_data = d;
        tick();
        disp_aeg_wr = 1'b0;
    endtask

    task automatic rd(input logic [17:0] idx, output logic [63:0] d, output logic v);
        disp_aeg_rd = 1'b1; disp_aeg_idx = idx;
        tick();
        d = disp_rtn_data; v = disp_rtn_data_vld;
        disp_aeg_rd = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [17:0] idx, input logic [63:0] exp);
        logic [63:0] d; logic v;
        rd(idx, d, v);
        chk(name, d, exp);
    endtask

    task automatic inst(input logic [4:0] code);
        disp_inst_vld = 1'b1; disp_inst = code;
        tick();
        disp_inst_vld = 1'b0;
    endtask

    // Start at cycle 0 of a run; returns in cycle 1 (LAUNCH).
    task automatic start();
        disp_inst_vld = 1'b1; disp_inst = 5'd0;
        #1;
        chk("stall_on_start", 64'(disp_stall), 64'd1);
        cyc = 0;
        tick();
        disp_inst_vld = 1'b0;
    endtask

    task automatic set_eng(input int i, input logic [GW-1:0] g, input logic [SW-1:0] e);
        eng_gvt[i*GW +: GW]    = g;
        eng_events[i*SW +: SW] = e;
    endtask

    task automatic done_at(input int k, input logic [NE-1:0] m);
        goto(k);
        eng_done = m;
        tick();
        eng_done = '0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [17:0] idx;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic [15:0] exp_exc;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [63:0] d;
        logic v;
        bit seen;

        vt[0]  = '{1'b1, 18'd0,       64'h1111, 64'h0,    16'h0};
        vt[1]  = '{1'b0, 18'd0,       64'h0,    64'h1111, 16'h0};
        vt[2]  = '{1'b1, 18'd9,       64'hDEAD, 64'h0,    16'h0};
        vt[3]  = '{1'b0, 18'd9,       64'h0,    64'hDEAD, 16'h0};
        vt[4]  = '{1'b1, 18'd15,      64'h5A,   64'h0,    16'h0};
        vt[5]  = '{1'b0, 18'd15,      64'h0,    64'h5A,   16'h0};
        vt[6]  = '{1'b1, 18'd5,       64'hFFFF, 64'h0,    16'h0};
        vt[7]  = '{1'b0, 18'd5,       64'h0,    64'h0,    16'h0};
        vt[8]  = '{1'b1, 18'd6,       64'h7B,   64'h0,    16'h0};
        vt[9]  = '{1'b0, 18'd6,       64'h0,    64'h0,    16'h0};
        vt[10] = '{1'b1, 18'd16,      64'h7,    64'h0,    16'h2};
        vt[11] = '{1'b0, 18'd16,      64'h0,    64'h0,    16'h2};
        vt[12] = '{1'b0, 18'h3FFFF,   64'h0,    64'h0,    16'h2};
        vt[13] = '{1'b1, 18'd1,       64'hABCD, 64'h0,    16'h0};
        vt[14] = '{1'b0, 18'd1,       64'h0,    64'hABCD, 16'h0};

        i_reset = 1'b1; disp_inst_vld = 0; disp_inst = 0; disp_aeg_idx = 0;
        disp_aeg_rd = 0; disp_aeg_wr = 0; disp_aeg_wr_data = 0;
        eng_done = 0; eng_gvt = 0; eng_events = 0;
        tick(); tick();
        chk("rst_start", 64'(eng_start), 64'd0);
        chk("rst_abort", 64'(eng_abort), 64'd0);
        chk("rst_exc", 64'(disp_exception), 64'd0);
        chk("rst_rtn_vld", 64'(disp_rtn_data_vld), 64'd0);
        chk("rst_idle", 64'(disp_idle), 64'd1);
        chk("rst_stall", 64'(disp_stall), 64'd0);
        chk("aeg_cnt", 64'(disp_aeg_cnt), 64'd16);
        i_reset = 1'b0;
        tick();

        // ---- table: AEG access in IDLE ----
        foreach (vt[i]) begin
            if (vt[i].is_wr) begin
                wr(vt[i].idx, vt[i].wdata);
                chk($sformatf("vec%0d_exc", i), 64'(disp_exception), 64'(vt[i].exp_exc));
            end else begin
                rd(vt[i].idx, d, v);
                chk($sformatf("vec%0d_vld", i), 64'(v), 64'd1);
                chk($sformatf("vec%0d_data", i), d, vt[i].exp_rd);
                chk($sformatf("vec%0d_exc", i), 64'(disp_exception), 64'(vt[i].exp_exc));
            end
        end
        tick();
        chk("exc_one_cycle", 64'(disp_exception), 64'd0);
        chk("cfg_aeg0", aeg_cfg[63:0], 64'h1111);
        chk("cfg_aeg1", aeg_cfg[127:64], 64'hABCD);
        inst(5'd3);
        chk("bad_inst_exc", 64'(disp_exception), 64'd1);
        tick();
        chk("bad_inst_exc_clr", 64'(disp_exception), 64'd0);

        // ---- run 1: four engines ----
        wr(18'd3, 64'hF);
        chk("cfg_aeg3", aeg_cfg[255:192], 64'hF);
        set_eng(0, 16'd40, 48'd5); set_eng(1, 16'd25, 48'd5);
        set_eng(2, 16'd90, 48'd5); set_eng(3, 16'd31, 48'd5);
        start();
        chk("r1_start", 64'(eng_start), 64'hF);
        chk("r1_idle_launch", 64'(disp_idle), 64'd0);
        tick();
        chk("r1_start_pulse", 64'(eng_start), 64'd0);
        chk("r1_stall_run", 64'(disp_stall), 64'd1);
        done_at(10, 4'b0011);
        done_at(20, 4'b0100);
        done_at(30, 4'b1000);
        chk("r1_idle_done", 64'(disp_idle), 64'd0);
        tick();
        chk("r1_idle_after", 64'(disp_idle), 64'd1);
        rd_chk("r1_gvt", 18'd6, 64'd25);
        rd_chk("r1_events", 18'd7, 64'd20);
        rd_chk("r1_cycles", 18'd8, 64'd29);
        rd_chk("r1_status", 18'd5, 64'd0);

        // ---- run 2: non-pending and duplicate completions ----
        wr(18'd3, 64'h5);
        start();
        set_eng(1, 16'd1, 48'd100);
        done_at(5, 4'b0010);
        set_eng(0, 16'd50, 48'd3);
        done_at(6, 4'b0001);
        set_eng(0, 16'd2, 48'd1000);
        done_at(8, 4'b0001);
        goto(12);
        chk("r2_still_run", 64'(disp_idle), 64'd0);
        set_eng(2, 16'd60, 48'd4);
        done_at(15, 4'b0100);
        tick();
        rd_chk("r2_gvt", 18'd6, 64'd50);
        rd_chk("r2_events", 18'd7, 64'd7);
        rd_chk("r2_cycles", 18'd8, 64'd14);

        // ---- run 3: abort with the final completion ----
        wr(18'd3, 64'h3);
        start();
        set_eng(0, 16'd7, 48'd9);
        done_at(10, 4'b0001);
        goto(12);
        eng_done = 4'b0010; disp_inst_vld = 1'b1; disp_inst = 5'd1;
        tick();
        eng_done = '0; disp_inst_vld = 1'b0;
        chk("r3_abort", 64'(eng_abort), 64'd1);
        chk("r3_idle", 64'(disp_idle), 64'd1);
        tick();
        chk("r3_abort_pulse", 64'(eng_abort), 64'd0);
        rd_chk("r3_status", 18'd5, 64'h8);
        rd_chk("r3_gvt_kept", 18'd6, 64'd50);
        rd_chk("r3_events_kept", 18'd7, 64'd7);
        rd_chk("r3_cycles", 18'd8, 64'd11);
        inst(5'd1);
        chk("idle_abort_ignored", 64'(eng_abort), 64'd0);

        // ---- run 4: exceptions and ignored requests during RUN ----
        wr(18'd3, 64'h1);
        start();
        goto(3);
        wr(18'd0, 64'hBEEF);
        chk("r4_busy_exc", 64'(disp_exception), 64'h8);
        tick();
        chk("r4_busy_exc_clr", 64'(disp_exception), 64'd0);
        inst(5'd3);
        chk("r4_bad_inst", 64'(disp_exception), 64'h1);
        inst(5'd0);
        chk("r4_restart_ignored", 64'(eng_start), 64'd0);
        rd_chk("r4_status_run", 18'd5, 64'h2);
        set_eng(0, 16'd9, 48'd1);
        done_at(10, 4'b0001);
        tick();
        rd_chk("r4_aeg0_kept", 18'd0, 64'h1111);
        rd_chk("r4_status_clr", 18'd5, 64'd0);

        // ---- run 5: empty mask goes straight to DONE ----
        wr(18'd3, 64'h0);
        start();
        chk("r5_start", 64'(eng_start), 64'd0);
        tick();
        tick();
        chk("r5_idle", 64'(disp_idle), 64'd1);
        rd_chk("r5_gvt", 18'd6, 64'hFFFF);
        rd_chk("r5_events", 18'd7, 64'd0);
        rd_chk("r5_cycles", 18'd8, 64'd0);

`ifdef PDES_WATCHDOG_EN
        // ---- watchdog timeout ----
        wr(18'd4, 64'd100);
        wr(18'd3, 64'h1);
        start();
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            if (eng_abort) seen = 1'b1;
        end
        chk("wd_seen", 64'(seen), 64'd1);
        chk("wd_cycle", 64'(cyc), 64'd102);
        chk("wd_exc", 64'(disp_exception), 64'h4);
        tick();
        rd_chk("wd_cycles", 18'd8, 64'd100);
        rd_chk("wd_status", 18'd5, 64'h4);
        wr(18'd4, 64'd0);
`else
        // ---- AEG4 is plain storage: no timeout ----
        seen = 1'b0;
        wr(18'd4, 64'd5);
        wr(18'd3, 64'h1);
        start();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (eng_abort) seen = 1'b1;
        end
        chk("nowd_no_abort", 64'(seen), 64'd0);
        done_at(22, 4'b0001);
        tick();
        rd_chk("nowd_cycles", 18'd8, 64'd21);
        rd_chk("nowd_status", 18'd5, 64'd0);
        rd_chk("nowd_aeg4", 18'd4, 64'd5);
`endif

        // ---- asynchronous reset mid-run, then a clean run ----
        wr(18'd3, 64'h1);
        start();
        goto(5);
        #2 i_reset = 1'b1;
        #1;
        chk("mr_idle", 64'(disp_idle), 64'd1);
        chk("mr_stall", 64'(disp_stall), 64'd0);
        chk("mr_cfg", aeg_cfg[255:0], 64'd0);
        chk("mr_exc", 64'(disp_exception), 64'd0);
        tick();
        i_reset = 1'b0;
        tick();
        rd_chk("mr_status", 18'd5, 64'd0);
        rd_chk("mr_aeg8", 18'd8, 64'd0);
        wr(18'd3, 64'h1);
        start();
        chk("mr2_start", 64'(eng_start), 64'h1);
        set_eng(0, 16'd77, 48'd11);
        done_at(4, 4'b0001);
        tick();
        rd_chk("mr2_gvt", 18'd6, 64'd77);
        rd_chk("mr2_events", 18'd7, 64'd11);
        rd_chk("mr2_cycles", 18'd8, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pdes_run_ctl.md
# pdes_run_ctl

Parametrised dispatch, AEG register-file and run-control block for the PDES personality. It sits between the dispatch interface and NUM_ENG simulation engines. It decodes start/abort instructions, fans out a start pulse to every enabled engine, and collects per-engine completions. It then reduces them into a minimum GVT, a summed event count and a run-cycle count, which software reads back through read-only AEGs.

## Interface
- NA, 16: number of AEG registers; power of two, 16..256.
- NUM_ENG, 4: number of engine channels, 1..16.
- GVT_W, 16: width of the per-engine GVT.
- STAT_W, 48: width of the per-engine event count; the sum is zero-extended to 64.
- clk  in  1  personality clock.
- i_reset  in  1  asynchronous, active-high reset.
- disp_inst_vld  in  1  instruction valid.
- disp_inst  in  5  instruction code.
- disp_aeg_idx  in  18  AEG index.
- disp_aeg_rd / disp_aeg_wr  in  1  AEG read / write strobes.
- disp_aeg_wr_data  in  64  AEG write data.
- disp_aeg_cnt  out  18  constant NA.
- disp_exception  out  16  one-cycle exception flags.
- disp_idle  out  1  controller idle.
- disp_stall  out  1  stall dispatch.
- disp_rtn_data_vld  out  1  read data valid.
- disp_rtn_data  out  64  read data.
- aeg_cfg  out  5*64  AEG[0..4] flattened, index 0 in the LSBs.
- eng_start  out  NUM_ENG  one-cycle start pulse per engine.
- eng_abort  out  1  one-cycle abort pulse to all engines.
- eng_done  in  NUM_ENG  per-engine completion pulse.
- eng_gvt  in  NUM_ENG*GVT_W  GVT, sampled when the matching eng_done is high.
- eng_events  in  NUM_ENG*STAT_W  event count, sampled with eng_done.

## Operation

**AEG map**
- 0: addr. 1: sim_end. 2: init_events. 3: engine mask, bits [NUM_ENG-1:0]. 4: watchdog limit.
- 5: status (read-only): {60'b0, aborted, timeout, state[1:0]}.
- 6: GVT result (read-only). 7: event total (read-only). 8: run cycles (read-only).
- 9..NA-1: scratch, read/write.

**AEG access rules**
- A write to index 5..8 is ignored.
- An index ≥ NA sets exception bit 1; a read of such an index returns 0.
- A write to index 0..4 while the state is not IDLE is dropped and sets exception bit 3.

**Instructions**
- 5'd0 is start; 5'd1 is abort.
- Any other code sets exception bit 0.
- Start outside IDLE and abort in IDLE are ignored.

**States**
- IDLE: on start, latch mask = AEG[3][NUM_ENG-1:0] and pending = mask, then go to LAUNCH.
- LAUNCH (1 cycle):
  - Pulse eng_start = mask.
  - Clear the accumulators: GVT accumulator to all-ones, event and cycle accumulators to 0.
  - Clear the status bits.
  - Go to RUN. If mask is 0, go directly to DONE instead.
- RUN:
  - The cycle counter increments every cycle and saturates at 2^64-1.
  - For each i with eng_done[i] & pending[i]: clear pending[i], set gvt_acc = min(gvt_acc, eng_gvt[i]), and add eng_events[i] to the event accumulator.
  - Several engines completing in the same cycle are all accumulated in that cycle.
  - eng_done from a non-pending engine is ignored.
  - When pending reaches 0 after the update, go to DONE.
- DONE (1 cycle): write AEG6 = gvt_acc zero-extended (all-ones GVT_W if mask was 0), AEG7 = event sum, AEG8 = cycles. Then go to IDLE.
- Abort in RUN: pulse eng_abort, set the aborted status bit, write AEG8, and go to IDLE. AEG6/7 keep their previous values.
- An abort and a final eng_done in the same cycle: abort wins.

**Reset**
- Resets asynchronously, at any point including mid-run.
- All AEGs clear to 0, the state goes to IDLE, and eng_start/eng_abort/exception/rtn_vld go to 0.
- disp_idle resets to 1 and disp_stall to 0.

## Timing
- AEG read: disp_aeg_rd at cycle N gives disp_rtn_data_vld and data at N+1.
- AEG write: write at N is visible on aeg_cfg and to reads from N+1.
- Start at N: LAUNCH and eng_start at N+1; RUN from N+2.
- Final eng_done at cycle M: DONE at M+1, results readable and disp_idle high at M+2.
- Run cycles counts RUN cycles only: N+2 through M inclusive.
- disp_stall = (state ≠ IDLE) | (start valid at the current cycle).
- disp_idle = (state == IDLE) & no start registered.
- Exceptions are registered and last exactly one cycle, one cycle after the offending request.

## Configuration
- PDES_WATCHDOG_EN defined:
  - A 64-bit counter runs in RUN.
  - When the cycle count equals AEG[4] and AEG[4] ≠ 0, pulse eng_abort, set the timeout status bit and exception bit 2, write AEG8, and go to IDLE.
- PDES_WATCHDOG_EN undefined: AEG[4] is plain storage, there is no timeout, and status bit 2 and exception bit 2 are tied to 0.

## Test plan
- Write AEG3=0xF, issue start; engines complete at cycles +10, +10, +20, +30 with GVTs 40, 25, 90, 31 and events 5 each -> AEG6=25, AEG7=20, AEG8=29, status state=IDLE.
- Write AEG3=0x5; pulse eng_done[1] and eng_done[0] twice -> done[1] ignored, duplicate done[0] ignored, finish only after eng_done[2].
- Issue abort during RUN in the same cycle as the last eng_done -> eng_abort pulses, status aborted=1, AEG6/7 unchanged.
- Issue disp_inst=5'd3, read AEG idx 16 (NA=16), write AEG0 during RUN -> exception bits 0, 1, 3 each pulse for one cycle; read returns 0; AEG0 unchanged.
- With PDES_WATCHDOG_EN, AEG4=100 and an engine never completing -> eng_abort after 100 RUN cycles, exception bit 2 set, AEG8=100.
- Assert i_reset mid-RUN -> all outputs reach reset values immediately, AEG5 reads 0, and a subsequent start behaves normally.
